spiker_spike_streamer: RTL
==========================

SPIKER_SPIKE_STREAMER -- requirements
Module: spiker_spike_streamer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the output word width in bits.
REQ-002 The block SHALL have parameter N_REG, default 24, giving the number of words per spike frame.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 768, giving the frame width; DATA_WIDTH SHALL equal WIDTH*N_REG, checked by elaboration assertion.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 data_i  input  DATA_WIDTH  spike frame from the register-sampling stage.
REQ-008 start_i  input  1  single-cycle request to capture data_i and stream it.
REQ-009 abort_i  input  1  cancels any frame in progress.
REQ-010 word_o  output  WIDTH  current spike word to the core.
REQ-011 idx_o  output  $clog2(N_REG)  index of word_o within the frame.
REQ-012 valid_o  output  1  word_o/idx_o valid.
REQ-013 ready_i  input  1  core accepts word; transfer = valid_o && ready_i.
REQ-014 busy_o  output  1  high in STREAM and DONE states.
REQ-015 done_o  output  1  single-cycle pulse after the last word transfers.
REQ-016 overrun_o  output  1  sticky flag: start_i seen while not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, STREAM and DONE.
REQ-018 In IDLE, start_i=1 with abort_i=0 SHALL capture data_i into an internal frame buffer, clear the index to 0 and go to STREAM next cycle.
REQ-019 Latency: with start_i at cycle t, valid_o SHALL be 1 at t+1 with word_o = data_i[WIDTH-1:0] as sampled at t.
REQ-020 Word k SHALL be frame bits [(k+1)*WIDTH-1 : k*WIDTH], emitted in order k = 0..N_REG-1, with idx_o = k.
REQ-021 In STREAM, valid_o SHALL be 1, and word_o/idx_o SHALL hold stable while ready_i=0.
REQ-022 On a transfer with idx < N_REG-1, the index SHALL increment by 1 on the next cycle.
REQ-023 On a transfer with idx = N_REG-1, the FSM SHALL go to DONE; valid_o SHALL be 0 in DONE.
REQ-024 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-025 With ready_i held at 1, the frame SHALL take N_REG cycles of valid_o; done_o SHALL be high at t+1+N_REG.
REQ-026 The frame buffer SHALL be unaffected by changes on data_i after capture.
REQ-027 start_i in STREAM or DONE SHALL be ignored for capture and SHALL set overrun_o.
REQ-028 overrun_o SHALL clear only on reset or on an accepted start in IDLE. An accepted start that coincides with a new overrun condition is impossible, since overrun requires a non-IDLE state.
REQ-029 abort_i=1 in any state SHALL force IDLE next cycle, with valid_o=0, idx_o=0 and no done_o pulse.
REQ-030 A transfer in the same cycle as abort_i SHALL count as accepted by the core, but SHALL NOT produce done_o.
REQ-031 abort_i and start_i together SHALL resolve as abort: no capture, stay IDLE, and overrun_o set only if not IDLE.
REQ-032 In IDLE, valid_o=0, busy_o=0 and word_o=0.

Reset
REQ-033 With rst_i=1 at a clock edge, the next state SHALL be IDLE, with word_o, idx_o, valid_o, busy_o, done_o and overrun_o all 0, and the frame buffer cleared to 0.
REQ-034 Reset SHALL take priority over start_i, abort_i and ready_i.
REQ-035 Reset mid-frame SHALL discard the frame with no done_o pulse.

Verification
REQ-036 Full frame, ready_i=1: load data_i with word k = 32'hA000_0000+k, then pulse start_i at t -> words A000_0000..A000_0017 at t+1..t+24 with idx_o 0..23, and done_o=1 only at t+25.
REQ-037 Backpressure: hold ready_i=0 for 5 cycles at idx 3 -> word_o = A000_0003 and idx_o = 3 stable, valid_o stays 1, and done_o is delayed by exactly 5 cycles.
REQ-038 Capture isolation: change data_i to all-ones at t+2 -> the streamed words still equal the frame sampled at t.
REQ-039 Overrun: start_i at idx 10 -> overrun_o=1, stream continues unchanged, and the next accepted start in IDLE clears overrun_o.
REQ-040 Abort at idx 7, with and without ready_i -> valid_o=0 and idx_o=0 next cycle, no done_o; a following start streams a full frame correctly.
REQ-041 Reset at idx 12 -> all outputs 0 next cycle, no done_o; start_i with abort_i in IDLE -> no valid_o.

Source files
------------

// File: rtl/spiker_spike_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : spiker_spike_streamer
//  Purpose  : Captures one wide spike frame on a start request and streams it
//             to the core as N_REG words of WIDTH bits, lowest word first,
//             with valid/ready handshaking. Abort or reset discards the frame.
//             A start that arrives while busy is dropped and flagged.
//  Ports    :
//     clk_i      in   1            sole clock, rising edge
//     rst_i      in   1            synchronous active-high reset
//     data_i     in   DATA_WIDTH   spike frame from the register-sampling stage
//     start_i    in   1            capture data_i and begin streaming
//     abort_i    in   1            cancel any frame in progress
//     word_o     out  WIDTH        current spike word
//     idx_o      out  IDX_W        index of word_o within the frame
//     valid_o    out  1            word_o/idx_o valid
//     ready_i    in   1            core accepts word (transfer = valid & ready)
//     busy_o     out  1            high while streaming or finishing
//     done_o     out  1            one-cycle pulse after the last transfer
//     overrun_o  out  1            sticky: start seen while not idle
//  Revision : 1.0  initial release
// ============================================================================
module spiker_spike_streamer #(
   parameter int WIDTH      = 32,
   parameter int N_REG      = 24,
   parameter int DATA_WIDTH = 768,
   // Index width; held at least 1 so a single-word frame still elaborates.
   parameter int IDX_W      = (N_REG > 1) ? $clog2(N_REG) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  start_i,
   input  logic                  abort_i,
   output logic [WIDTH-1:0]      word_o,
   output logic [IDX_W-1:0]      idx_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  overrun_o
);

   // ------------------------------------------------------------------------
   // Configuration check: the frame must split exactly into N_REG words.
   // ------------------------------------------------------------------------
   if (DATA_WIDTH != WIDTH * N_REG) begin : g_cfg_check
      $error("spiker_spike_streamer: DATA_WIDTH must equal WIDTH*N_REG");
   end

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_STREAM = 2'd1;
   localparam logic [1:0] c_DONE   = 2'd2;

   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_REG - 1);
   localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   logic [1:0]            state_q,   state_d;
   logic [IDX_W-1:0]      idx_q,     idx_d;
   logic [DATA_WIDTH-1:0] frame_q,   frame_d;
   logic                  overrun_q, overrun_d;

   // Frame buffer viewed as an array of words for indexed selection.
   logic [WIDTH-1:0] w_words [N_REG];

   for (genvar k = 0; k < N_REG; k++) begin : g_words
      assign w_words[k] = frame_q[k*WIDTH +: WIDTH];
   end

   logic w_is_idle;
   logic w_is_stream;
   logic w_is_done;
   logic w_xfer;
   logic w_accept_start;

   assign w_is_idle      = (state_q == c_IDLE);
   assign w_is_stream    = (state_q == c_STREAM);
   assign w_is_done      = (state_q == c_DONE);
   assign w_xfer         = w_is_stream && ready_i;
   assign w_accept_start = w_is_idle && start_i && !abort_i;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      frame_d   = frame_q;
      overrun_d = overrun_q;

      // A start outside IDLE is never captured but is always remembered,
      // even when it coincides with an abort.
      if (start_i && !w_is_idle) begin
         overrun_d = 1'b1;
      end

      if (abort_i) begin
         // Abort wins over everything else; a coincident transfer is
         // considered taken by the core but never completes the frame.
         state_d = c_IDLE;
         idx_d   = '0;
      end else begin
         case (state_q)
            c_IDLE: begin
               if (w_accept_start) begin
                  frame_d   = data_i;
                  idx_d     = '0;
                  overrun_d = 1'b0;
                  state_d   = c_STREAM;
               end
            end
            c_STREAM: begin
               if (w_xfer) begin
                  if (idx_q == c_LAST_IDX) begin
                     idx_d   = '0;
                     state_d = c_DONE;
                  end else begin
                     idx_d = idx_q + c_IDX_ONE;
                  end
               end
            end
            c_DONE: begin
               state_d = c_IDLE;
            end
            default: begin
               state_d = c_IDLE;
               idx_d   = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= c_IDLE;
         idx_q     <= '0;
         frame_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         frame_q   <= frame_d;
         overrun_q <= overrun_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: all decoded from registered state, so they change only on
   // clock edges and hold steady while the core back-pressures.
   // ------------------------------------------------------------------------
   assign valid_o   = w_is_stream;
   assign busy_o    = w_is_stream || w_is_done;
   assign done_o    = w_is_done;
   assign idx_o     = idx_q;
   assign overrun_o = overrun_q;
   assign word_o    = w_is_stream ? w_words[idx_q] : '0;

endmodule
`default_nettype wire
